load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data/address width; only 32 is supported.
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_valid  in  1  core request present.
REQ-005 SHALL have port: req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-006 SHALL have port: req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port: req_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-008 SHALL have port: req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port: req_addr  in  WIDTH  byte address.
REQ-010 SHALL have port: req_wdata  in  WIDTH  store data, low-aligned.
REQ-011 SHALL have port: resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_rdata  out  WIDTH  extended load data; 0 for stores and errors.
REQ-013 SHALL have port: resp_err  out  1  request faulted; qualified by resp_valid.
REQ-014 SHALL have port: mem_ren, mem_wen  out  1 each  memory read/write strobes.
REQ-015 SHALL have port: mem_addr  out  WIDTH  memory byte address.
REQ-016 SHALL have port: mem_wdata  out  WIDTH  full-word write data, little-endian.
REQ-017 SHALL have port: mem_rdata  in  WIDTH  memory read data; valid at the rising edge ending a mem_ren cycle, held while mem_ren is low.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL, on accept, register addr/size/unsigned/wdata; later req_* changes have no effect on the access.
REQ-020 SHALL go: load IDLE->LOAD->RESP; word store IDLE->STORE->RESP; byte/half store IDLE->RMW_RD->RMW_WR->RESP; fault IDLE->RESP; RESP->IDLE always.
REQ-021 SHALL drive mem_ren=1 only in LOAD and RMW_RD, and mem_wen=1 only in STORE and RMW_WR, both decoded from registered state only; never both high.
REQ-022 SHALL drive mem_addr=registered addr with low 2 bits cleared for byte/half accesses and unmodified for word accesses.
REQ-023 SHALL, in LOAD, capture mem_rdata at the closing edge, extract the byte/half at addr[1:0] (half at addr[1]), and extend per req_unsigned.
REQ-024 SHALL, in RMW_WR, drive mem_wdata = mem_rdata with the addressed byte/half lanes replaced by req_wdata low bits.
REQ-025 SHALL assert resp_valid for exactly the RESP cycle with no backpressure: load/store latency 2 cycles after accept, sub-word store 3, fault 1.
REQ-026 SHALL fault req_size=3 unconditionally with resp_err=1 and no memory strobe.
REQ-027 SHALL ignore req_valid outside IDLE; a request arriving during RESP is accepted the following cycle.

Reset
REQ-028 SHALL, on rst asserted at any time including mid-RMW, force IDLE, mem_ren=mem_wen=0, resp_valid=0, resp_err=0, resp_rdata=0, and registered request fields to 0, without waiting for clk.
REQ-029 SHALL drive req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with MISALIGN_TRAP_EN defined, fault any half access with addr[0]=1 and any word access with addr[1:0]!=0: IDLE->RESP, resp_err=1, no strobe.
REQ-031 SHALL, without MISALIGN_TRAP_EN, perform misaligned word accesses at the exact byte address and align misaligned halves down to the half boundary, with no fault.

Structure
REQ-032 SHALL use a shared package lsu_pkg that holds the size encoding enum, the FSM state enum, and the width constants.
REQ-033 SHALL use one combinational sub-module lsu_align that performs load lane extraction/extension and store lane merge.

Verification
REQ-034 SHALL cover, with word 0x100=0x8899AABB: LB 0x103 -> resp_rdata=0xFFFFFF88; LBU 0x103 -> 0x00000088; LH 0x100 -> 0xFFFFAABB; each resp_valid exactly 2 cycles after accept.
REQ-035 SHALL cover SH 0x102 with wdata 0x00001234 -> RMW_RD then RMW_WR with mem_wdata=0x1234AABB, resp_valid 3 cycles after accept, then LW 0x100 -> 0x1234AABB.
REQ-036 SHALL cover LW 0x101 with MISALIGN_TRAP_EN -> resp_err=1 and resp_rdata=0 one cycle after accept, mem_ren never high; without the macro -> mem_addr=0x101 and no error.
REQ-037 SHALL cover rst pulsed during RMW_WR of SB 0x200 -> mem_wen drops before the next clk, state IDLE, no resp_valid.
REQ-038 SHALL cover back-to-back SW 0x300=0xDEADBEEF with req_valid held high -> second request accepted the cycle after RESP, req_ready=0 in between.
REQ-039 SHALL cover req_size=3 -> resp_err=1 with no strobe in both configurations.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam int unsigned LSU_WIDTH = 32;
    localparam int unsigned LSU_BYTES = LSU_WIDTH / 8;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } lsu_state_e;

    function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
        return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational load lane extract/extend and store lane merge.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]           i_addr_lo,
    input  lsu_size_e            i_size,
    input  logic                 i_unsigned,
    input  logic [LSU_WIDTH-1:0] i_rdata,
    input  logic [LSU_WIDTH-1:0] i_wdata,
    output logic [LSU_WIDTH-1:0] o_load_data,
    output logic [LSU_WIDTH-1:0] o_store_data
);

    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [LSU_BYTES-1:0] w_be;
    logic [LSU_WIDTH-1:0] w_wrep;

    // Misaligned halves use addr[1] only, which aligns them down.
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_HALF: o_load_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    always_comb begin
        w_be   = 4'hF;
        w_wrep = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                w_be   = 4'(4'b0001 << i_addr_lo);
                w_wrep = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'hF;
                w_wrep = i_wdata;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < LSU_BYTES; gi++) begin : g_lane
            assign o_store_data[8*gi +: 8] = w_be[gi] ? w_wrep[8*gi +: 8] : i_rdata[8*gi +: 8];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit with sub-word RMW stores.
//               Define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_e       r_state;
    logic [WIDTH-1:0] r_addr;
    lsu_size_e        r_size;
    logic             r_unsigned;
    logic [WIDTH-1:0] r_wdata;
    logic             r_err;
    logic [WIDTH-1:0] r_rdata;

    lsu_size_e        w_req_size;
    logic             w_fault;
    logic [WIDTH-1:0] w_load_data;
    logic [WIDTH-1:0] w_store_data;

    assign w_req_size = lsu_size_e'(req_size);

`ifdef MISALIGN_TRAP_EN
    assign w_fault = (w_req_size == SZ_ILLEGAL) || is_misaligned(w_req_size, req_addr[1:0]);
`else
    assign w_fault = (w_req_size == SZ_ILLEGAL);
`endif

    lsu_align u_align (
        .i_addr_lo    (r_addr[1:0]),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_rdata      (mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_size     <= w_req_size;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata;
                        r_rdata    <= '0;
                        r_err      <= w_fault;
                        if (w_fault) begin
                            r_state <= RESP;
                        end else if (!req_we) begin
                            r_state <= LOAD;
                        end else if (w_req_size == SZ_WORD) begin
                            r_state <= STORE;
                        end else begin
                            r_state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    r_rdata <= w_load_data;
                    r_state <= RESP;
                end
                STORE:  r_state <= RESP;
                RMW_RD: r_state <= RMW_WR;
                RMW_WR: r_state <= RESP;
                RESP: begin
                    // Clear so the response fields read as zero outside RESP.
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_err   = r_err;
    assign resp_rdata = r_rdata;

    assign mem_ren   = (r_state == LOAD) || (r_state == RMW_RD);
    assign mem_wen   = (r_state == STORE) || (r_state == RMW_WR);
    assign mem_addr  = (r_size == SZ_WORD) ? r_addr : {r_addr[WIDTH-1:2], 2'b00};
    assign mem_wdata = mem_wen ? w_store_data : '0;

endmodule

`default_nettype wire
